ps2_rx_ctrl: RTL
================

Name: ps2_rx_ctrl

Overview:
- Frame-receive controller for the keyboard serial link (SCLK/SDATA): 11-bit frame of start, 8 data LSB-first, odd parity, stop.
- Synchronises SCLK/SDATA into the CLK domain and detects SCLK falling edges.
- Sequences bit capture with an FSM, validates start/parity/stop, recovers from stalled frames by timeout.
- Delivers the scan code with a one-cycle NEW_CODE strobe; sits between the pad inputs and the code-consuming logic.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops on SCLK and SDATA (≥2).
- TIMEOUT_CYCLES, 5000, CLK cycles allowed between consecutive SCLK falling edges inside a frame.

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RST  in  1  reset, synchronous, active-high.
- SCLK  in  1  asynchronous link clock; idles high.
- SDATA  in  1  asynchronous link data; idles high.
- EN  in  1  receive enable; 0 forces IDLE.
- CODE  out  8  last valid scan code.
- NEW_CODE  out  1  one-cycle strobe: CODE updated this cycle.
- FRAME_ERR  out  1  one-cycle strobe: frame rejected.
- ERR_CODE  out  2  cause of last rejection: 0 none, 1 parity, 2 stop, 3 timeout.
- BUSY  out  1  high while state ≠ IDLE.

Behaviour:
- Reset: synchroniser and edge-history flops reset to 1, which prevents a false edge. State is IDLE, bit_cnt is 0, and the timeout counter is 0. CODE, NEW_CODE, FRAME_ERR, ERR_CODE and BUSY are all 0.
- Falling edge (fe): high for exactly one cycle when the synchronised SCLK history is 1 and the current value is 0. SDATA is sampled from its synchroniser in the same cycle.
- IDLE:
  - fe with EN=1 and SDATA=0 → RECV, bit_cnt=0, timer cleared, ERR_CODE cleared to 0.
  - fe with SDATA=1 → ignored; stay IDLE with no strobe.
- RECV:
  - On each fe, bit_cnt 0..7 shifts SDATA into the data register LSB-first: new bit enters bit 7, register shifts right.
  - bit_cnt 8 captures parity; bit_cnt 9 captures stop and moves to CHECK.
  - bit_cnt increments per fe; the timer clears on every fe.
- Timeout: in RECV the timer increments each cycle without fe. Reaching TIMEOUT_CYCLES-1 → IDLE, FRAME_ERR=1 next cycle, ERR_CODE=3. Timer width is $clog2(TIMEOUT_CYCLES).
- CHECK (exactly one cycle):
  - Parity is good when the XOR over data[7:0] and the parity bit equals 1.
  - Stop is good when the stop bit equals 1.
  - Both good → CODE<=data, NEW_CODE=1.
  - Otherwise FRAME_ERR=1 and CODE is held. ERR_CODE=2 if stop is bad (stop has priority over parity), else 1.
  - Always returns to IDLE.
- Latency: if the stop-bit fe is detected in cycle N, then state=CHECK in N+1 and NEW_CODE/FRAME_ERR/CODE are visible in N+2. The strobes are low in all other cycles.
- NEW_CODE and FRAME_ERR are never high together.
- ERR_CODE holds until the next start bit is accepted.
- EN=0 in RECV/CHECK: abort to IDLE next cycle; no strobe, ERR_CODE unchanged, CODE unchanged.
- RST mid-frame: everything returns to reset values with no strobe. The partial frame is discarded; the next start bit begins cleanly.
- Back-to-back frames: a fe arriving in the CHECK cycle is lost. This is acceptable because the link's minimum bit period far exceeds 2 CLK cycles.

Decomposition:
- Package ps2_rx_pkg:
  - state enum {IDLE, RECV, CHECK}.
  - ERR_NONE/ERR_PARITY/ERR_STOP/ERR_TIMEOUT constants (2-bit).
  - FRAME_BITS=11 and DATA_BITS=8.
- Sub-module ps2_sync_edge: parameterised SYNC_STAGES synchroniser for SCLK and SDATA plus the falling-edge detector. Outputs are sclk_fe and sdata_s; flops reset to 1.

Test Plan:
- Valid frame 0x1C (start 0, data LSB-first, parity 0, stop 1), EN=1 → NEW_CODE one pulse 2 cycles after the stop edge; CODE=0x1C, ERR_CODE=0, FRAME_ERR never high.
- Frame 0x1C with parity 1 → FRAME_ERR pulse, ERR_CODE=1, CODE keeps its previous value, NEW_CODE stays 0. A frame with stop 0 and good parity → ERR_CODE=2. A frame with stop 0 and bad parity → ERR_CODE=2.
- Stall after 5 SCLK edges for >TIMEOUT_CYCLES → FRAME_ERR pulse exactly TIMEOUT_CYCLES cycles after the last edge, ERR_CODE=3, BUSY falls. A following valid frame 0xF0 (parity 1) → CODE=0xF0, ERR_CODE=0.
- SCLK fe with SDATA=1 while IDLE, then a valid frame 0x5A (parity 1) → the spurious edge is ignored (BUSY stays 0) and CODE=0x5A.
- RST asserted for 1 cycle after bit 4 of a frame → all outputs 0, no strobe. The remaining edges of that frame are ignored or rejected without NEW_CODE; the next valid frame 0x29 (parity 0) is received correctly.
- EN deasserted mid-frame → BUSY=0 next cycle, no strobes, CODE unchanged. With EN=0, a full valid frame produces no strobe.

Source files
------------

// File: rtl/ps2_rx_pkg.sv
// Shared types and constants for the keyboard-link frame receiver.
package ps2_rx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    CHECK = 2'd2
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_PARITY  = 2'd1;
  localparam logic [1:0] ERR_STOP    = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  localparam int FRAME_BITS = 11;
  localparam int DATA_BITS  = 8;

endpackage

// File: rtl/ps2_sync_edge.sv
// Brings SCLK/SDATA into the clk domain and flags SCLK falling edges.
module ps2_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic sclk,
  input  logic sdata,
  output logic sclk_fe,
  output logic sdata_s
);

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] sdata_sync;
  logic                   sclk_hist;

  // Reset to the idle-high line level so leaving reset never looks like an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync  <= '1;
      sdata_sync <= '1;
      sclk_hist  <= 1'b1;
    end else begin
      sclk_sync  <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      sdata_sync <= {sdata_sync[SYNC_STAGES-2:0], sdata};
      sclk_hist  <= sclk_sync[SYNC_STAGES-1];
    end
  end

  assign sclk_fe = sclk_hist & ~sclk_sync[SYNC_STAGES-1];
  assign sdata_s = sdata_sync[SYNC_STAGES-1];

endmodule

// File: rtl/ps2_rx_ctrl.sv
// Keyboard-link frame receiver: start, 8 data bits LSB-first, odd parity, stop.
// state | meaning
// IDLE  | waiting for a start bit (SDATA low on an SCLK falling edge)
// RECV  | shifting data, parity and stop bits; stall timer running
// CHECK | one cycle to validate parity/stop and publish the code
module ps2_rx_ctrl
  import ps2_rx_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       SCLK,
  input  logic       SDATA,
  input  logic       EN,
  output logic [7:0] CODE,
  output logic       NEW_CODE,
  output logic       FRAME_ERR,
  output logic [1:0] ERR_CODE,
  output logic       BUSY
);

  localparam int                TMR_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 2);
  localparam logic [3:0]        PAR_IDX  = 4'(DATA_BITS);
  localparam logic [3:0]        STOP_IDX = 4'(FRAME_BITS - 2);

  logic                 sclk_fe;
  logic                 sdata_s;
  state_t               state_q, state_d;
  logic [3:0]           bit_cnt;
  logic [DATA_BITS-1:0] data_q;
  logic                 par_q;
  logic                 stop_q;
  logic [TMR_W-1:0]     tmr_q;
  logic [7:0]           code_q;
  logic                 new_code_q;
  logic                 frame_err_q;
  logic [1:0]           err_q;
  logic                 accept_start;
  logic                 take_bit;
  logic                 code_ok;
  logic                 frame_bad;
  logic [1:0]           err_d;
  logic                 parity_ok;

  ps2_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk     (CLK),
    .rst     (RST),
    .sclk    (SCLK),
    .sdata   (SDATA),
    .sclk_fe (sclk_fe),
    .sdata_s (sdata_s)
  );

  assign parity_ok = ^{data_q, par_q};

  always_ff @(posedge CLK) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    accept_start = 1'b0;
    take_bit     = 1'b0;
    code_ok      = 1'b0;
    frame_bad    = 1'b0;
    err_d        = err_q;
    case (state_q)
      IDLE: begin
        if (EN && sclk_fe && !sdata_s) begin
          state_d      = RECV;
          accept_start = 1'b1;
        end
      end
      RECV: begin
        if (!EN) begin
          state_d = IDLE;
        end else if (sclk_fe) begin
          take_bit = 1'b1;
          if (bit_cnt == STOP_IDX) state_d = CHECK;
        end else if (tmr_q == TMR_LAST) begin
          // Timer steps to TIMEOUT_CYCLES-1 now; error strobe lands with the step.
          state_d   = IDLE;
          frame_bad = 1'b1;
          err_d     = ERR_TIMEOUT;
        end
      end
      CHECK: begin
        state_d = IDLE;
        if (EN) begin
          if (stop_q && parity_ok) begin
            code_ok = 1'b1;
          end else begin
            frame_bad = 1'b1;
            err_d     = !stop_q ? ERR_STOP : ERR_PARITY;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      bit_cnt <= '0;
      data_q  <= '0;
      par_q   <= 1'b0;
      stop_q  <= 1'b0;
      tmr_q   <= '0;
    end else begin
      if (state_q == RECV && !sclk_fe) tmr_q <= tmr_q + TMR_W'(1);
      else                             tmr_q <= '0;

      if (accept_start) begin
        bit_cnt <= '0;
      end else if (take_bit) begin
        bit_cnt <= bit_cnt + 4'd1;
        if (bit_cnt < PAR_IDX)        data_q <= {sdata_s, data_q[DATA_BITS-1:1]};
        else if (bit_cnt == PAR_IDX)  par_q  <= sdata_s;
        else                          stop_q <= sdata_s;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      code_q      <= '0;
      new_code_q  <= 1'b0;
      frame_err_q <= 1'b0;
      err_q       <= ERR_NONE;
    end else begin
      new_code_q  <= code_ok;
      frame_err_q <= frame_bad;
      if (code_ok) code_q <= data_q;
      if (accept_start)   err_q <= ERR_NONE;
      else if (frame_bad) err_q <= err_d;
    end
  end

  assign CODE      = code_q;
  assign NEW_CODE  = new_code_q;
  assign FRAME_ERR = frame_err_q;
  assign ERR_CODE  = err_q;
  assign BUSY      = (state_q != IDLE);

endmodule
